// File: rtl/counter_pkg.sv
// Shared constants for the flexible counter: direction and limit-mode encodings.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

endpackage : counter_pkg

// File: rtl/counter_next_calc.sv
// Combinational step logic: the value, overflow pulse and saturation flag that an
// enabled count step would produce from the current state.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SAT_MODE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] dout,
    input  logic [WIDTH-1:0] max_val,
    input  logic             up_dn,
    input  logic             busy_sat,
    output logic [WIDTH-1:0] next_val,
    output logic             next_ovf,
    output logic             next_busy
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Next-state for one enabled step in the current direction
    always_comb begin
        next_val  = dout;
        next_ovf  = 1'b0;
        next_busy = 1'b0;
        if (up_dn == DIR_UP) begin
            if (dout >= max_val) begin
                if (SAT_MODE == MODE_SAT) begin
                    // Already parked at the limit: no new pulse, unless we came from
                    // above the limit (max_val shrank under us).
                    next_val  = max_val;
                    next_ovf  = !busy_sat || (dout != max_val);
                    next_busy = 1'b1;
                end else begin
                    next_val  = ZERO;
                    next_ovf  = 1'b1;
                end
            end else begin
                next_val = dout + ONE;
                // Stepping onto the limit from below is the saturation event itself.
                if (SAT_MODE == MODE_SAT && next_val == max_val) begin
                    next_ovf  = 1'b1;
                    next_busy = 1'b1;
                end
            end
        end else begin
            if (dout == ZERO) begin
                if (SAT_MODE == MODE_SAT) begin
                    next_val  = ZERO;
                    next_ovf  = !busy_sat;
                    next_busy = 1'b1;
                end else begin
                    next_val  = max_val;
                    next_ovf  = 1'b1;
                end
            end else begin
                // An out-of-range value is pulled back into range rather than decremented.
                next_val = (dout > max_val) ? max_val : (dout - ONE);
                if (SAT_MODE == MODE_SAT && next_val == ZERO) begin
                    next_ovf  = 1'b1;
                    next_busy = 1'b1;
                end
            end
        end
    end

endmodule : counter_next_calc

// File: rtl/counter_flex.sv
// Parametrised up/down counter with load, programmable modulo limit, wrap or
// saturate behaviour, and terminal-count / overflow flags.
module counter_flex
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0,
    parameter int          SAT_MODE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] dout,
    output logic             tc,
    output logic             ovf,
    output logic             busy_sat
);

    localparam logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] dout_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] step_val;
    logic             step_ovf;
    logic             step_busy;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .SAT_MODE (SAT_MODE)
    ) u_next_calc (
        .dout      (dout_reg),
        .max_val   (max_val),
        .up_dn     (up_dn),
        .busy_sat  (busy_reg),
        .next_val  (step_val),
        .next_ovf  (step_ovf),
        .next_busy (step_busy)
    );

    // State registers with priority reset > load > enabled step > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_reg <= RESET_VALUE;
            ovf_reg  <= 1'b0;
            busy_reg <= 1'b0;
        end else if (load) begin
            dout_reg <= load_val;
            ovf_reg  <= 1'b0;
            busy_reg <= 1'b0;
        end else if (en) begin
            dout_reg <= step_val;
            ovf_reg  <= step_ovf;
            busy_reg <= step_busy;
        end else begin
            ovf_reg  <= 1'b0;
        end
    end

    // Terminal count looks at the limit in the active direction, same cycle
    always_comb begin
        tc = en && ((up_dn == DIR_UP) ? (dout_reg == max_val) : (dout_reg == '0));
    end

    assign dout     = dout_reg;
    assign ovf      = ovf_reg;
    assign busy_sat = busy_reg;

endmodule : counter_flex

// File: doc/counter_flex.md
Name: counter_flex

Overview:
Parametrised successor to the team's basic 4-bit free-running up counter. Adds configurable width, up/down counting, enable, synchronous load, programmable modulo limit, saturate-or-wrap mode, and terminal-count/overflow flags. Serves as the general-purpose counter for timers, dividers and event counting in the debug/test fabric; the single-clock, registered-output style is unchanged.

Parameters:
WIDTH, 8, counter bit width (>=2)
RESET_VAL, 0, value loaded on reset (must be <= 2**WIDTH-1)
SAT_MODE, 0, 0 = wrap at limits; 1 = saturate at limits

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset: synchronous, active-high
en  input  1  count enable; count advances only when high
up_dn  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous load request
load_val  input  WIDTH  value loaded when load=1
max_val  input  WIDTH  upper count limit (inclusive); lower limit is always 0
dout  output  WIDTH  current count (registered)
tc  output  1  terminal count: combinational, high when en=1 and dout is at the active limit (max_val for up, 0 for down)
ovf  output  1  registered one-cycle pulse on wrap or saturation hit
busy_sat  output  1  registered; high while held at a limit in SAT_MODE=1

Behaviour:
- All state updates occur on posedge clk. Priority: reset > load > en > hold.
- Reset: dout=RESET_VAL, ovf=0, busy_sat=0. Reset mid-count discards the count. Reset with load=1 at the same time: reset wins.
- Load: dout<=load_val regardless of en; ovf<=0; busy_sat<=0. If load_val>max_val, the loaded value is taken as-is. The next enabled up step is then an out-of-range case (see below).
- Enabled up, dout<max_val: dout<=dout+1; ovf<=0.
- Enabled up, dout>=max_val:
  - wrap: dout<=0, ovf<=1.
  - sat: dout<=max_val, ovf<=1 only on the first cycle the limit is reached from below or from an out-of-range value, busy_sat<=1.
- Enabled down, dout>0: dout<=dout-1, clamped to max_val if dout>max_val; ovf<=0.
- Enabled down, dout==0:
  - wrap: dout<=max_val, ovf<=1.
  - sat: dout<=0, ovf<=1 on first arrival only, busy_sat<=1.
- busy_sat clears on any step away from the limit, on a direction reversal that moves off the limit, on load, and on reset.
- en=0: dout holds; ovf<=0; busy_sat holds.
- max_val==0: up or down wrap each enabled cycle keeps dout=0 with ovf=1 every cycle (wrap mode). In sat mode, ovf pulses once and then busy_sat=1.
- Latency: count change is visible on dout one cycle after the enabling edge; tc is same-cycle combinational.
- Arithmetic is WIDTH-bit unsigned with no sign extension; max_val=2**WIDTH-1 gives natural full-range wrap.
- max_val may change at any time. The new limit takes effect on the next edge.

Decomposition:
- Package counter_pkg: direction constants (DIR_UP=1, DIR_DN=0), mode constants (MODE_WRAP=0, MODE_SAT=1).
- One sub-module, counter_next_calc: combinational next-value, limit-hit and ovf logic. The top level holds the registers and priority mux.

Test Plan:
- Reset then en=1, up, WIDTH=8, max_val=5, wrap -> dout 0,1,2,3,4,5,0. ovf=1 on the edge to 0. tc high while dout=5.
- Down count from load_val=2, max_val=9, wrap -> 2,1,0,9,8. ovf pulses once on 0->9.
- SAT_MODE=1, up, max_val=3 -> 0,1,2,3,3,3. ovf single pulse. busy_sat=1 from first 3. Switching to down gives 2 and busy_sat=0.
- load=1, load_val=0xAA, en=0 -> dout=0xAA next cycle. Simultaneous reset=1 and load=1 -> dout=RESET_VAL.
- en toggled 1,0,0,1 while counting up from 7 -> 8,8,8,9. ovf stays 0.
- load_val=20 with max_val=10: up/wrap -> 0 with ovf=1. Down -> 10.
